// File: rtl/y_mux4to1_if.sv
`default_nettype none
// ============================================================================
//  Module   : y_mux4to1_if
//  Purpose  : Bundles the operand, select and result signals of the
//             y_mux4to1 word multiplexer.
//  Signals  : a0..a3  SIZE-bit operands
//             c       2-bit select
//             en      capture enable for the registered copy
//             z       combinational selected operand
//             z_q     registered selected operand
//             valid_q z_q holds a captured value
//  Modports : master - source side (drives operands/select/enable)
//             slave  - the multiplexer itself
//  Revision : 1.0 - initial release
// ============================================================================
interface y_mux4to1_if #(
   parameter int SIZE = 32
);
   logic [SIZE-1:0] a0;
   logic [SIZE-1:0] a1;
   logic [SIZE-1:0] a2;
   logic [SIZE-1:0] a3;
   logic [1:0]      c;
   logic            en;
   logic [SIZE-1:0] z;
   logic [SIZE-1:0] z_q;
   logic            valid_q;

   modport master (
      output a0, a1, a2, a3, c, en,
      input  z, z_q, valid_q
   );

   modport slave (
      input  a0, a1, a2, a3, c, en,
      output z, z_q, valid_q
   );
endinterface
`default_nettype wire

// File: rtl/y_mux4to1.sv
`default_nettype none
// ============================================================================
//  Module   : y_mux4to1
//  Purpose  : Four-input SIZE-bit word multiplexer. Provides a zero-latency
//             combinational result plus a registered copy with a sticky
//             valid flag for pipelined consumers.
//  Ports    : clk    rising-edge clock (registered path only)
//             rst_n  asynchronous active-low reset (registered path only)
//             bus    y_mux4to1_if.slave: a0..a3, c, en in; z, z_q, valid_q out
//  Notes    : SIZE must match the SIZE of the connected interface; legal
//             range is 1..64.
//  Revision : 1.0 - initial release
// ============================================================================
module y_mux4to1 #(
   parameter int SIZE = 32
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   y_mux4to1_if.slave  bus
);

   logic [SIZE-1:0] w_lo;
   logic [SIZE-1:0] w_hi;
   logic [SIZE-1:0] w_z;
   logic [SIZE-1:0] r_z_q;
   logic            r_valid_q;

   // Two-level tree: c[0] picks within each pair, c[1] picks the pair.
   assign w_lo = bus.c[0] ? bus.a1 : bus.a0;
   assign w_hi = bus.c[0] ? bus.a3 : bus.a2;
   assign w_z  = bus.c[1] ? w_hi   : w_lo;

   // valid_q is sticky: it only ever returns to 0 through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z_q     <= '0;
         r_valid_q <= 1'b0;
      end else if (bus.en) begin
         r_z_q     <= w_z;
         r_valid_q <= 1'b1;
      end
   end

   assign bus.z       = w_z;
   assign bus.z_q     = r_z_q;
   assign bus.valid_q = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_y_mux4to1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_y_mux4to1
//  Purpose  : Self-checking bench for y_mux4to1 at SIZE=32 and SIZE=8.
//             Expected values are queued when stimulus is applied and
//             popped when the result is sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_y_mux4to1;

   logic clk;
   logic rst_n;

   y_mux4to1_if #(.SIZE(32)) bus32 ();
   y_mux4to1_if #(.SIZE(8))  bus8 ();

   y_mux4to1 #(.SIZE(32)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32)
   );

   y_mux4to1 #(.SIZE(8)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];
   logic [7:0]  exp8_q[$];
   logic [31:0] exp_reg_q[$];
   logic [7:0]  exp_reg8_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_sel(input logic [31:0] v0, input logic [31:0] v1,
                                           input logic [31:0] v2, input logic [31:0] v3,
                                           input logic [1:0] sel);
      case (sel)
         2'd0:    return v0;
         2'd1:    return v1;
         2'd2:    return v2;
         default: return v3;
      endcase
   endfunction

   // Apply operands to both widths and queue the expected combinational result.
   task automatic drive_ops(input logic [31:0] v0, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] v3,
                            input logic [1:0] sel);
      logic [31:0] e;
      bus32.a0 = v0; bus32.a1 = v1; bus32.a2 = v2; bus32.a3 = v3; bus32.c = sel;
      bus8.a0  = v0[7:0]; bus8.a1 = v1[7:0]; bus8.a2 = v2[7:0]; bus8.a3 = v3[7:0];
      bus8.c   = sel;
      e = ref_sel(v0, v1, v2, v3, sel);
      exp_q.push_back(e);
      exp8_q.push_back(e[7:0]);
   endtask

   task automatic check_comb(input string tag);
      logic [31:0] e;
      logic [7:0]  e8;
      #1;
      e  = exp_q.pop_front();
      e8 = exp8_q.pop_front();
      check(tag, {32'd0, bus32.z}, {32'd0, e});
      check({tag, "_w8"}, {56'd0, bus8.z}, {56'd0, e8});
   endtask

   task automatic set_en(input logic v);
      bus32.en = v;
      bus8.en  = v;
   endtask

   task automatic check_reg(input string tag, input logic exp_valid);
      logic [31:0] e;
      logic [7:0]  e8;
      e  = exp_reg_q.pop_front();
      e8 = exp_reg8_q.pop_front();
      check({tag, "_zq"}, {32'd0, bus32.z_q}, {32'd0, e});
      check({tag, "_vq"}, {63'd0, bus32.valid_q}, {63'd0, exp_valid});
      check({tag, "_zq_w8"}, {56'd0, bus8.z_q}, {56'd0, e8});
      check({tag, "_vq_w8"}, {63'd0, bus8.valid_q}, {63'd0, exp_valid});
   endtask

   task automatic expect_reg(input logic [31:0] v);
      exp_reg_q.push_back(v);
      exp_reg8_q.push_back(v[7:0]);
   endtask

   initial begin
      logic [31:0] r0, r1, r2, r3;
      logic [1:0]  rc;
      int          err_before;

      rst_n = 1'b0;
      set_en(1'b0);
      drive_ops(32'd0, 32'd0, 32'd0, 32'd0, 2'd0);
      #2;
      exp_q.delete();
      exp8_q.delete();
      expect_reg(32'd0);
      check_reg("reset", 1'b0);
      #1 rst_n = 1'b1;

      // Exhaustive select with one-hot style operands.
      for (int s = 0; s < 4; s++) begin
         drive_ops(32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h8000_0000, 2'(s));
         check_comb($sformatf("onehot_c%0d", s));
      end

      // Bit-independence patterns.
      for (int s = 0; s < 4; s++) begin
         drive_ops(32'hFFFF_FFFF, 32'h0000_0000, 32'hAAAA_AAAA, 32'h5555_5555, 2'(s));
         check_comb($sformatf("bits_c%0d", s));
      end

      // Random operands and select.
      for (int i = 0; i < 100; i++) begin
         r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
         rc = 2'($urandom % 4);
         err_before = n_err;
         drive_ops(r0, r1, r2, r3, rc);
         check_comb($sformatf("rand%0d", i));
         if (n_err != err_before)
            $display("  operands: a0=%h a1=%h a2=%h a3=%h c=%0d", r0, r1, r2, r3, rc);
      end

      // en held low so far: registered path must still read as reset.
      expect_reg(32'd0);
      check_reg("idle_hold", 1'b0);

      // Registered capture of a2.
      @(negedge clk);
      drive_ops(32'h1234_5678, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'hCAFE_0001, 2'd2);
      check_comb("cap_comb");
      set_en(1'b1);
      expect_reg(32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      set_en(1'b0);
      check_reg("capture", 1'b1);

      // en low: z follows the new select, z_q holds.
      drive_ops(32'h1234_5678, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'hCAFE_0001, 2'd0);
      check_comb("hold_comb");
      expect_reg(32'hDEAD_BEEF);
      check_reg("hold_now", 1'b1);
      @(posedge clk);
      #1;
      expect_reg(32'hDEAD_BEEF);
      check_reg("hold_edge", 1'b1);

      // Asynchronous reset between edges.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      expect_reg(32'd0);
      check_reg("async_rst", 1'b0);
      drive_ops(32'h1234_5678, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'hCAFE_0001, 2'd3);
      check_comb("rst_comb");

      // Reset held low overrides en across an edge.
      set_en(1'b1);
      @(posedge clk);
      #1;
      expect_reg(32'd0);
      check_reg("rst_hold", 1'b0);

      // Release off-edge; first enabled edge captures the current z.
      #2 rst_n = 1'b1;
      expect_reg(32'hCAFE_0001);
      @(posedge clk);
      #1;
      set_en(1'b0);
      check_reg("post_rst_cap", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      n_err++;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/y_mux4to1.md
Name: y_mux4to1

Overview:
- Parameterised four-input word multiplexer for the datapath: selects one of four SIZE-bit operands a0..a3 using a 2-bit select c.
- Provides a zero-latency combinational output z, which is the primary datapath use, plus a registered copy z_q with a valid flag for pipelined consumers.
- Sits between the register-file/immediate sources and the ALU/writeback stages.

Parameters:
- SIZE, 32, width in bits of each data input and of z/z_q; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for the registered path only.
- rst_n  input  1  asynchronous active-low reset for the registered path.
- a0  input  SIZE  operand selected when c=0.
- a1  input  SIZE  operand selected when c=1.
- a2  input  SIZE  operand selected when c=2.
- a3  input  SIZE  operand selected when c=3.
- c  input  2  select.
- en  input  1  capture enable for the registered path.
- z  output  SIZE  combinational selected operand.
- z_q  output  SIZE  registered selected operand.
- valid_q  output  1  high when z_q holds a captured value.

Behaviour:
- Combinational path:
  - z = a0 when c=2'b00, a1 when c=2'b01, a2 when c=2'b10, a3 when c=2'b11.
  - Purely combinational; no clock or reset dependence.
  - Settles within the same simulation time step (well under 1 time unit) after any input change.
- Structure of the combinational path: two first-level 2:1 muxes, lo = c[0] ? a1 : a0 and hi = c[0] ? a3 : a2, then z = c[1] ? hi : lo.
  - Bit-for-bit identical on every one of the SIZE bits.
  - No bit reordering, sign extension or truncation.
- Unknown select: if c contains X/Z, z is not required to be defined. Bench checks only apply with c fully 0/1.
- Registered path:
  - On rst_n low, asynchronously and immediately: z_q = 0 and valid_q = 0, regardless of clk.
  - While rst_n is low, these values hold.
  - On rising clk with rst_n high and en=1: z_q <= the current z value; valid_q <= 1. Latency is 1 cycle.
  - On rising clk with rst_n high and en=0: z_q and valid_q hold their previous values.
  - Once set, valid_q stays 1 until the next reset.
- Reset mid-operation: asserting rst_n clears z_q and valid_q immediately. z continues to track the inputs unaffected.
- Reset release: deassertion is asynchronous to clk. The first capture happens at the first rising clk edge with rst_n high and en=1.
- Simultaneous events: an input or c change in the same cycle as a capture edge captures the value present just before the edge (standard flop sampling).
- No internal state other than the SIZE+1 flops. No handshake beyond en.

Test Plan:
- Exhaustive select, combinational: a0=32'h0000_0001, a1=32'h0000_0002, a2=32'h0000_0004, a3=32'h8000_0000; step c through 0..3 with #1 between steps -> z = 1, 2, 4, 8000_0000 respectively.
- Random: at least 2 iterations (bench default ≥100) of $random a0..a3 and c=$random%4, checked after #1 -> z must equal a[c] exactly (!== compare); print PASS/FAIL with all operands.
- Width/bit independence: a0=all-ones, a1=0, a2=32'hAAAA_AAAA, a3=32'h5555_5555; cycle c -> z matches every bit. Repeat with SIZE=8 -> z[7:0] correct.
- Registered capture:
  - After reset, valid_q=0 and z_q=0.
  - Set c=2, a2=32'hDEAD_BEEF, en=1, one clk edge -> z_q=DEAD_BEEF, valid_q=1.
  - Then en=0, change c to 0 -> z follows a0 immediately while z_q holds DEAD_BEEF.
- Async reset mid-run: with z_q=DEAD_BEEF, pull rst_n low between clk edges -> z_q=0 and valid_q=0 without a clk edge; z still equals a[c].
